multiplier_rr: RTL
==================

Name: multiplier_rr

Overview:
- Parametrised successor to the two-unit ping-pong multiplier.
- LANES independent iterative shift-add multiplier lanes, issued round-robin and retired in order through valid/ready handshakes.
- Sustains up to LANES multiplies in flight with no dependence on a divided clock.
- Sits between the execute stage and writeback; signed/unsigned selectable per operation; overflow flagged per result.

Parameters:
- WIDTH, 32, operand and result width in bits (>=4).
- LANES, 2, number of multiplier lanes (>=1, power of 2).
- TAGW, 5, width of the caller tag carried with each operation.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  lane at issue pointer can accept.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_signed  in  1  1 = two's-complement, 0 = unsigned.
- in_tag  in  TAGW  caller tag, returned unchanged.
- out_valid  out  1  result at retire pointer ready.
- out_ready  in  1  consumer accepts result.
- out  out  WIDTH  low WIDTH bits of product.
- out_tag  out  TAGW  tag of the returned operation.
- exception  out  1  product does not fit in WIDTH bits under selected signedness.
- busy  out  1  any lane not idle.

Behaviour:
- Reset (reset=0, async): all lanes IDLE; issue_ptr=0; retire_ptr=0; in_ready=0 while reset is low; out_valid=0, out=0, out_tag=0, exception=0, busy=0. Any in-flight operations are discarded.
- Lane FSM: IDLE -> RUN (on accept) -> DONE (after WIDTH iterations) -> IDLE (on retire). Each lane holds its own operands, accumulator, iteration counter, tag and sign flag.
- in_ready = lane[issue_ptr] is IDLE.
- Accept: when in_valid & in_ready, capture the operands.
  - Signed: store magnitudes |a| and |b|, plus neg = sign(a) XOR sign(b).
  - Unsigned: store raw operands, neg = 0.
  - Increment issue_ptr modulo LANES.
- RUN: one partial product per clock, LSB-first. Counter runs 0..WIDTH-1; the 2*WIDTH accumulator is unsigned.
  - After the last iteration, apply negation if neg, compute exception, and enter DONE.
  - Operation accepted on edge t: lane enters DONE at edge t+WIDTH.
  - out_valid is high from edge t+WIDTH at the earliest, if that lane is at retire_ptr.
- Exception:
  - Unsigned: upper WIDTH bits of the full product are nonzero.
  - Signed: full 2*WIDTH signed product is not equal to the sign-extension of its low WIDTH bits.
  - The most-negative operand is handled via magnitude with width WIDTH+1 internal, or an equivalent method.
- Retire: out, out_tag and exception are driven from lane[retire_ptr] when it is in DONE.
  - On out_valid & out_ready, that lane returns to IDLE and retire_ptr advances modulo LANES.
  - Results leave in strict acceptance order.
- Backpressure: while out_ready=0, out, out_tag and exception hold stable with out_valid high. Other lanes keep running to DONE and wait.
- Simultaneous accept and retire on the same lane in one cycle is not possible; the lane must be IDLE to accept. Simultaneous accept on one lane and retire on another is allowed.
- With LANES=1: accept, then WIDTH cycles, then result; no overlap.
- Zero operands: follow the normal iteration path with no early-out. Latency is fixed at WIDTH cycles.
- Pointer wrap-around: LANES-1 -> 0.
- busy = OR of (lane not IDLE).

Optional Feature:
- Macro: MULT_HI_EN.
- Defined: adds output port out_hi (WIDTH bits), the upper WIDTH bits of the signed or unsigned full product. It is held with out under backpressure and reset to 0.
- Undefined: port absent; upper accumulator bits are used only for exception.

Test Plan:
- WIDTH=32, LANES=2: accept a=7, b=6, unsigned -> out=42, exception=0, out_valid exactly 32 cycles after the accept edge.
- Signed a=-3 (0xFFFFFFFD), b=5 -> out=0xFFFFFFF1, exception=0. Unsigned, same operands -> out=0xFFFFFFF1, exception=1. With MULT_HI_EN: out_hi=0xFFFFFFFF for signed, 0x00000004 for unsigned.
- Back-to-back accepts of tags 1, 2, 3 with out_ready=1:
  - Tags 1 and 2 accepted on consecutive cycles; tag 3 stalls (in_ready=0) until tag 1 retires.
  - Results emerge in order 1, 2, 3.
- Hold out_ready=0 for 50 cycles after out_valid: out and out_tag stay stable; the second lane completes but is not presented; in_ready=0. Release -> both results drain on consecutive cycles.
- Signed 0x80000000 * 0xFFFFFFFF -> out=0x80000000, exception=1. Signed 0x00010000 * 0x00008000 -> out=0x80000000, exception=1.
- Drive reset low mid-RUN with two ops in flight -> out_valid=0 and busy=0 immediately. After release: in_ready=1 and a new op 2*2 returns out=4 with the tag of the new op.

Source files
------------

// File: rtl/multiplier_rr_if.sv
// Handshake bundle between the execute stage and the round-robin multiplier.
// Define MULT_HI_EN to carry the upper product half as out_hi.
interface multiplier_rr_if #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_signed;
  logic [TAGW-1:0]  in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [TAGW-1:0]  out_tag;
  logic             exception;
  logic             busy;
`ifdef MULT_HI_EN
  logic [WIDTH-1:0] out_hi;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out, out_tag, exception, busy, out_hi
  );
  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out, out_tag, exception, busy, out_hi
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out, out_tag, exception, busy
  );
  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out, out_tag, exception, busy
  );
`endif
endinterface

// File: rtl/multiplier_rr.sv
// LANES iterative shift-add multiplier lanes, issued round-robin and retired in order.
// Define MULT_HI_EN to expose the upper WIDTH bits of the product on out_hi.
module multiplier_rr #(
  parameter int WIDTH = 32,
  parameter int LANES = 2,
  parameter int TAGW  = 5
) (
  input logic            clock,
  input logic            reset,
  multiplier_rr_if.slave bus
);
  localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} laneState_t;

  laneState_t         state_q  [LANES];
  laneState_t         state_d  [LANES];
  logic [WIDTH-1:0]   mcand_q  [LANES];
  logic [WIDTH-1:0]   mcand_d  [LANES];
  logic [2*WIDTH-1:0] acc_q    [LANES];
  logic [2*WIDTH-1:0] acc_d    [LANES];
  logic [CW-1:0]      cnt_q    [LANES];
  logic [CW-1:0]      cnt_d    [LANES];
  logic [TAGW-1:0]    tag_q    [LANES];
  logic [TAGW-1:0]    tag_d    [LANES];
  logic               neg_q    [LANES];
  logic               neg_d    [LANES];
  logic               sgn_q    [LANES];
  logic               sgn_d    [LANES];
  logic               exc_q    [LANES];
  logic               exc_d    [LANES];
  logic [PW-1:0]      issuePtr_q, issuePtr_d;
  logic [PW-1:0]      retirePtr_q, retirePtr_d;

  logic [2*WIDTH-1:0] stepAcc  [LANES];
  logic [2*WIDTH-1:0] finalAcc [LANES];
  logic               finalExc [LANES];
  logic [LANES-1:0]   laneBusy;

  logic             aNeg, bNeg, accept, retire;
  logic [WIDTH-1:0] magA, magB;

  // Signed operands run through the unsigned datapath as magnitudes; -MIN fits as unsigned.
  assign aNeg = bus.in_signed & bus.in_a[WIDTH-1];
  assign bNeg = bus.in_signed & bus.in_b[WIDTH-1];
  assign magA = aNeg ? (-bus.in_a) : bus.in_a;
  assign magB = bNeg ? (-bus.in_b) : bus.in_b;

  // Accumulator holds {partial product, remaining multiplier bits}; one shift-add per clock.
  for (genvar l = 0; l < LANES; l++) begin : gLane
    logic [WIDTH:0] sum;
    assign sum = {1'b0, acc_q[l][2*WIDTH-1:WIDTH]} + (acc_q[l][0] ? {1'b0, mcand_q[l]} : '0);
    assign stepAcc[l]  = {sum, acc_q[l][WIDTH-1:1]};
    assign finalAcc[l] = neg_q[l] ? (-stepAcc[l]) : stepAcc[l];
    assign finalExc[l] = sgn_q[l]
                         ? (finalAcc[l][2*WIDTH-1:WIDTH] != {WIDTH{finalAcc[l][WIDTH-1]}})
                         : (finalAcc[l][2*WIDTH-1:WIDTH] != '0);
    assign laneBusy[l] = (state_q[l] != IDLE);
  end

  assign bus.in_ready  = reset && (state_q[issuePtr_q] == IDLE);
  assign bus.out_valid = (state_q[retirePtr_q] == DONE);
  assign bus.out       = bus.out_valid ? acc_q[retirePtr_q][WIDTH-1:0] : '0;
  assign bus.out_tag   = bus.out_valid ? tag_q[retirePtr_q] : '0;
  assign bus.exception = bus.out_valid && exc_q[retirePtr_q];
  assign bus.busy      = |laneBusy;
`ifdef MULT_HI_EN
  assign bus.out_hi    = bus.out_valid ? acc_q[retirePtr_q][2*WIDTH-1:WIDTH] : '0;
`endif

  assign accept = bus.in_valid && bus.in_ready;
  assign retire = bus.out_valid && bus.out_ready;

  always_comb begin
    issuePtr_d  = issuePtr_q;
    retirePtr_d = retirePtr_q;
    for (int l = 0; l < LANES; l++) begin
      state_d[l] = state_q[l];
      mcand_d[l] = mcand_q[l];
      acc_d[l]   = acc_q[l];
      cnt_d[l]   = cnt_q[l];
      tag_d[l]   = tag_q[l];
      neg_d[l]   = neg_q[l];
      sgn_d[l]   = sgn_q[l];
      exc_d[l]   = exc_q[l];
      case (state_q[l])
        RUN: begin
          if (cnt_q[l] == CW'(WIDTH - 1)) begin
            acc_d[l]   = finalAcc[l];
            exc_d[l]   = finalExc[l];
            state_d[l] = DONE;
          end else begin
            acc_d[l] = stepAcc[l];
            cnt_d[l] = cnt_q[l] + 1'b1;
          end
        end
        DONE: begin
          if (retire && (retirePtr_q == PW'(l))) begin
            state_d[l] = IDLE;
          end
        end
        default: begin
          if (accept && (issuePtr_q == PW'(l))) begin
            mcand_d[l] = magA;
            acc_d[l]   = {{WIDTH{1'b0}}, magB};
            cnt_d[l]   = '0;
            tag_d[l]   = bus.in_tag;
            neg_d[l]   = aNeg ^ bNeg;
            sgn_d[l]   = bus.in_signed;
            exc_d[l]   = 1'b0;
            state_d[l] = RUN;
          end
        end
      endcase
    end
    if (accept) begin
      issuePtr_d = (issuePtr_q == PW'(LANES - 1)) ? '0 : issuePtr_q + 1'b1;
    end
    if (retire) begin
      retirePtr_d = (retirePtr_q == PW'(LANES - 1)) ? '0 : retirePtr_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      issuePtr_q  <= '0;
      retirePtr_q <= '0;
      for (int l = 0; l < LANES; l++) begin
        state_q[l] <= IDLE;
        mcand_q[l] <= '0;
        acc_q[l]   <= '0;
        cnt_q[l]   <= '0;
        tag_q[l]   <= '0;
        neg_q[l]   <= 1'b0;
        sgn_q[l]   <= 1'b0;
        exc_q[l]   <= 1'b0;
      end
    end else begin
      issuePtr_q  <= issuePtr_d;
      retirePtr_q <= retirePtr_d;
      for (int l = 0; l < LANES; l++) begin
        state_q[l] <= state_d[l];
        mcand_q[l] <= mcand_d[l];
        acc_q[l]   <= acc_d[l];
        cnt_q[l]   <= cnt_d[l];
        tag_q[l]   <= tag_d[l];
        neg_q[l]   <= neg_d[l];
        sgn_q[l]   <= sgn_d[l];
        exc_q[l]   <= exc_d[l];
      end
    end
  end
endmodule
